// File: rtl/sb_pkg.sv
// Shared types for the issue/writeback scoreboard.
// FU state encoding and the functional-unit index map.
package sb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } fu_state_t;

  localparam int FU_ALU  = 0;
  localparam int FU_MEM  = 1;
  localparam int FU_MUL  = 2;
  localparam int FU_DIV  = 3;
  localparam int FU_JUMP = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, one-hot grant,
// pointer advances to the slot after the winner.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [PW-1:0] next_ptr
);

  int idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    next_ptr  = ptr;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
        next_ptr  = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/fu_scoreboard.sv
// Multi-FU issue/writeback scoreboard: hazard checks at issue,
// per-FU result buffering and one round-robin writeback per cycle.
module fu_scoreboard #(
  parameter int NUM_FU = 5,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int FW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [FW-1:0]          issue_fu,
  input  logic [REG_AW-1:0]      issue_rs1,
  input  logic                   issue_rs1_used,
  input  logic [REG_AW-1:0]      issue_rs2,
  input  logic                   issue_rs2_used,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   issue_rd_we,
  output logic                   issue_ready,
  output logic [NUM_FU-1:0]      fu_en,
  input  logic [NUM_FU-1:0]      fu_done,
  input  logic [NUM_FU*XLEN-1:0] fu_data,
  output logic                   wb_valid,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic [NUM_FU-1:0]      fu_busy,
  output logic                   err
);

  import sb_pkg::*;

  localparam int NREG = 2 ** REG_AW;

  fu_state_t         st_q  [NUM_FU];
  fu_state_t         st_d  [NUM_FU];
  logic [REG_AW-1:0] rd_q  [NUM_FU];
  logic [REG_AW-1:0] rd_d  [NUM_FU];
  logic              we_q  [NUM_FU];
  logic              we_d  [NUM_FU];
  logic [XLEN-1:0]   res_q [NUM_FU];
  logic [XLEN-1:0]   res_d [NUM_FU];

  logic [NREG-1:0]   pend_q, pend_d;
  logic [FW-1:0]     ptr_q, ptr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic [NUM_FU-1:0] req, gnt;
  logic              gnt_valid;
  logic [FW-1:0]     next_ptr;
  logic              sel_busy;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_busy[i] = (st_q[i] != IDLE);
      req[i]     = (st_q[i] == DONE);
    end
  end

  rr_arbiter #(
    .N  (NUM_FU),
    .PW (FW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .next_ptr  (next_ptr)
  );

  // Out-of-range FU index reads as busy so it can never issue.
  always_comb begin
    sel_busy = 1'b1;
    for (int i = 0; i < NUM_FU; i++)
      if (issue_fu == FW'(i)) sel_busy = fu_busy[i];
    issue_ready = !sel_busy
      && !(issue_rs1_used && pend_q[issue_rs1])
      && !(issue_rs2_used && pend_q[issue_rs2])
      && !(issue_rd_we && pend_q[issue_rd]);
    for (int i = 0; i < NUM_FU; i++)
      fu_en[i] = issue_valid && issue_ready
        && (issue_fu == FW'(i));
  end

  always_comb begin
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    for (int i = 0; i < NUM_FU; i++) begin
      st_d[i]  = st_q[i];
      rd_d[i]  = rd_q[i];
      we_d[i]  = we_q[i];
      res_d[i] = res_q[i];
      case (st_q[i])
        IDLE: if (fu_en[i]) begin
          st_d[i] = EXEC;
          rd_d[i] = issue_rd;
          we_d[i] = issue_rd_we;
        end
        EXEC: if (fu_done[i]) begin
          st_d[i]  = DONE;
          res_d[i] = fu_data[i*XLEN +: XLEN];
        end
        DONE: if (gnt[i]) begin
          st_d[i]    = IDLE;
          wb_valid_d = we_q[i] && (rd_q[i] != '0);
          wb_rd_d    = rd_q[i];
          wb_data_d  = res_q[i];
          if (we_q[i] && (rd_q[i] != '0))
            pend_d[rd_q[i]] = 1'b0;
        end
        default: st_d[i] = IDLE;
      endcase
      if (fu_done[i] && (st_q[i] != EXEC)) err_d = 1'b1;
    end
    if (gnt_valid) ptr_d = next_ptr;
    if (issue_valid && issue_ready && issue_rd_we
        && (issue_rd != '0))
      pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        st_q[i]  <= IDLE;
        rd_q[i]  <= '0;
        we_q[i]  <= 1'b0;
        res_q[i] <= '0;
      end
      pend_q     <= '0;
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        st_q[i]  <= st_d[i];
        rd_q[i]  <= rd_d[i];
        we_q[i]  <= we_d[i];
        res_q[i] <= res_d[i];
      end
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fu_scoreboard.sv
// Bench for fu_scoreboard: directed ops, expected writebacks
// queued at fu_done time and popped by a monitor.
module tb_fu_scoreboard;

  import sb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic [2:0]   issue_fu;
  logic [4:0]   issue_rs1;
  logic         issue_rs1_used;
  logic [4:0]   issue_rs2;
  logic         issue_rs2_used;
  logic [4:0]   issue_rd;
  logic         issue_rd_we;
  logic         issue_ready;
  logic [4:0]   fu_en;
  logic [4:0]   fu_done;
  logic [159:0] fu_data;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [4:0]   fu_busy;
  logic         err;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  fu_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_fu       (issue_fu),
    .issue_rs1      (issue_rs1),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2      (issue_rs2),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_rd_we    (issue_rd_we),
    .issue_ready    (issue_ready),
    .fu_en          (fu_en),
    .fu_done        (fu_done),
    .fu_data        (fu_data),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .fu_busy        (fu_busy),
    .err            (err)
  );

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_op(input int fu, input int rd,
                        input bit we, input int rs1,
                        input bit u1, input int rs2,
                        input bit u2, input bit v);
    issue_fu       = 3'(fu);
    issue_rd       = 5'(rd);
    issue_rd_we    = we;
    issue_rs1      = 5'(rs1);
    issue_rs1_used = u1;
    issue_rs2      = 5'(rs2);
    issue_rs2_used = u2;
    issue_valid    = v;
  endtask

  task automatic issue_ok(input string name, input int fu,
                          input int rd);
    @(negedge clk);
    set_op(fu, rd, 1, 0, 0, 0, 0, 1);
    #1;
    check(name, issue_ready, 1);
  endtask

  task automatic done(input logic [4:0] m);
    fu_done = m;
  endtask

  // Monitor: every writeback must match the head of the queue.
  always @(posedge clk) begin
    logic [36:0] e;
    #1;
    if (rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_extra rd=%0d data=%h none expected",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", 64'(wb_rd), 64'(e[36:32]));
        check("wb_data", 64'(wb_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    fu_done = '0;
    fu_data = '0;

    // Reset state
    @(negedge clk);
    set_op(FU_ALU, 4, 1, 3, 1, 0, 0, 0);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", fu_busy, 0);
    check("rst_ready", issue_ready, 1);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single op, minimum latency
    @(negedge clk);
    set_op(FU_ALU, 5, 1, 0, 0, 0, 0, 1);
    #1;
    check("single_ready", issue_ready, 1);
    check("single_en", fu_en, 5'b00001);
    @(negedge clk);
    issue_valid = 0;
    done(5'b00001);
    fu_data[0 +: 32] = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    #1;
    check("single_busy_exec", fu_busy, 5'b00001);
    @(negedge clk);
    done(0);
    #1;
    check("single_wb_early", wb_valid, 0);
    check("single_busy_done", fu_busy, 5'b00001);
    @(negedge clk);
    #1;
    check("single_wb_t3", wb_valid, 1);
    check("single_wb_rd", wb_rd, 5);
    check("single_wb_data", wb_data, 32'h1234);
    check("single_busy_clr", fu_busy, 0);

    // RAW on x7
    @(negedge clk);
    set_op(FU_MUL, 7, 1, 0, 0, 0, 0, 1);
    #1;
    check("raw_mul_ready", issue_ready, 1);
    check("raw_mul_en", fu_en, 5'b00100);
    @(negedge clk);
    set_op(FU_ALU, 8, 1, 7, 1, 0, 0, 1);
    #1;
    check("raw_blk_exec", issue_ready, 0);
    check("raw_blk_en", fu_en, 0);
    @(negedge clk);
    done(5'b00100);
    fu_data[64 +: 32] = 32'hCAFE;
    exp_q.push_back({5'd7, 32'hCAFE});
    #1;
    check("raw_blk_done_in", issue_ready, 0);
    @(negedge clk);
    done(0);
    #1;
    check("raw_blk_nobypass", issue_ready, 0);
    @(negedge clk);
    #1;
    check("raw_release", issue_ready, 1);
    check("raw_release_en", fu_en, 5'b00001);
    @(negedge clk);
    issue_valid = 0;
    done(5'b00001);
    fu_data[0 +: 32] = 32'h8888;
    exp_q.push_back({5'd8, 32'h8888});
    @(negedge clk);
    done(0);
    repeat (2) @(negedge clk);

    // Contention with pointer at 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue_ok("cont_i0", FU_ALU, 1);
    issue_ok("cont_i2", FU_MUL, 2);
    issue_ok("cont_i3", FU_DIV, 3);
    @(negedge clk);
    issue_valid = 0;
    done(5'b01101);
    fu_data[0 +: 32]  = 32'hA1;
    fu_data[64 +: 32] = 32'hA2;
    fu_data[96 +: 32] = 32'hA3;
    exp_q.push_back({5'd1, 32'hA1});
    exp_q.push_back({5'd2, 32'hA2});
    exp_q.push_back({5'd3, 32'hA3});
    @(negedge clk);
    done(0);
    @(negedge clk);
    #1;
    check("cont_wb1", {wb_valid, wb_rd}, {1'b1, 5'd1});
    @(negedge clk);
    #1;
    check("cont_wb2", {wb_valid, wb_rd}, {1'b1, 5'd2});
    @(negedge clk);
    #1;
    check("cont_wb3", {wb_valid, wb_rd}, {1'b1, 5'd3});
    issue_ok("cont_i1", FU_MEM, 10);
    issue_ok("cont_i4", FU_JUMP, 11);
    @(negedge clk);
    issue_valid = 0;
    done(5'b10010);
    fu_data[32 +: 32]  = 32'hB10;
    fu_data[128 +: 32] = 32'hB11;
    exp_q.push_back({5'd11, 32'hB11});
    exp_q.push_back({5'd10, 32'hB10});
    @(negedge clk);
    done(0);
    @(negedge clk);
    #1;
    check("cont_wb11", {wb_valid, wb_rd}, {1'b1, 5'd11});
    @(negedge clk);
    #1;
    check("cont_wb10", {wb_valid, wb_rd}, {1'b1, 5'd10});

    // x0 and WAW
    issue_ok("x0_issue", FU_ALU, 0);
    @(negedge clk);
    set_op(FU_MEM, 9, 1, 0, 1, 0, 0, 1);
    #1;
    check("x0_not_pending", issue_ready, 1);
    @(negedge clk);
    set_op(FU_DIV, 9, 1, 0, 0, 0, 0, 0);
    #1;
    check("waw_blk", issue_ready, 0);
    set_op(FU_ALU, 12, 1, 0, 0, 0, 0, 0);
    #1;
    check("struct_blk", issue_ready, 0);
    set_op(5, 14, 1, 0, 0, 0, 0, 0);
    #1;
    check("fu_range_blk", issue_ready, 0);
    done(5'b00011);
    fu_data[0 +: 32]  = 32'hDEAD;
    fu_data[32 +: 32] = 32'h9999;
    exp_q.push_back({5'd9, 32'h9999});
    @(negedge clk);
    done(0);
    @(negedge clk);
    set_op(FU_DIV, 9, 1, 0, 0, 0, 0, 0);
    #1;
    check("x0_wb_silent", wb_valid, 0);
    check("waw_blk_done", issue_ready, 0);
    @(negedge clk);
    #1;
    check("waw_wb9", {wb_valid, wb_rd}, {1'b1, 5'd9});
    check("waw_release", issue_ready, 1);

    // Spurious done and reset mid-EXEC
    @(negedge clk);
    done(5'b00010);
    @(negedge clk);
    done(0);
    #1;
    check("err_set", err, 1);
    @(negedge clk);
    #1;
    check("err_sticky", err, 1);
    issue_ok("rst_mid_issue", FU_MUL, 13);
    @(negedge clk);
    issue_valid = 0;
    #1;
    check("rst_mid_busy", fu_busy, 5'b00100);
    rst = 1'b0;
    set_op(FU_MUL, 13, 1, 13, 1, 0, 0, 0);
    #1;
    check("rst_mid_busy_clr", fu_busy, 0);
    check("rst_mid_err_clr", err, 0);
    check("rst_mid_wb", wb_valid, 0);
    check("rst_mid_pend_clr", issue_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
